lpc_frame_sequencer: RTL
========================

# lpc_frame_sequencer

Frame-level scheduler for the LPC analysis chain. It starts the autocorrelation engine, runs the Levinson–Durbin datapath once that engine finishes, and then streams the ORDER+1 predictor coefficients out of the shared coefficient memory over a valid/ready port. It owns the read address of the coefficient memory and multiplexes it between the Levinson datapath and its own readout. It also holds the datapath in reset whenever the datapath is not running.

## Interface
- ORDER, 10: predictor order; coefficients a[0..ORDER] live at addresses 0..ORDER.
- TIMEOUT, 65535: maximum number of cycles allowed in AC_RUN or in LEV_RUN.
- FCNT_W, 16: width of the frame counter.

Ports:
- clk  in  1  system clock. Single clock domain.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  single-cycle pulse: a frame of samples is ready.
- busy  out  1  high in every state except IDLE.
- ac_start  out  1  single-cycle pulse that starts autocorrelation.
- ac_done  in  1  single-cycle pulse: the r[] memory is complete.
- lev_reset  out  1  reset to the Levinson datapath. Low only in LEV_RUN.
- lev_ready  in  1  Levinson completion level.
- lev_a_rsel  in  10  coefficient read address driven by the Levinson datapath.
- a_rsel  out  10  muxed read address to the coefficient memory.
- a_r  in  32  coefficient memory read data. Registered read, 1-cycle latency.
- out_valid  out  1  coefficient word valid.
- out_ready  in  1  downstream accept.
- out_data  out  32  coefficient word.
- out_last  out  1  high with a[ORDER].
- overrun  out  1  sticky: frame_start arrived while busy.
- timeout_err  out  1  sticky: a watchdog expired.
- frame_cnt  out  FCNT_W  number of frames fully streamed.

## Operation
States: IDLE, AC_RUN, LEV_RUN, RD_ADDR, RD_WAIT, RD_OUT.
- IDLE:
  - lev_reset=1 and a_rsel=0.
  - On frame_start: pulse ac_start for one cycle, clear the watchdog, go to AC_RUN.
- AC_RUN:
  - On ac_done: go to LEV_RUN and clear the watchdog.
  - On watchdog==TIMEOUT-1: set timeout_err, go to IDLE.
- LEV_RUN:
  - lev_reset=0 and a_rsel=lev_a_rsel (combinational pass-through).
  - lev_ready is ignored in the first LEV_RUN cycle.
  - From the second cycle on, lev_ready=1 → RD_ADDR with idx=0.
  - Watchdog rule is the same as in AC_RUN.
- RD_ADDR:
  - Drive a_rsel=idx, go to RD_WAIT.
- RD_WAIT:
  - Capture a_r into the out_data register, go to RD_OUT.
- RD_OUT:
  - out_valid=1; out_last=(idx==ORDER).
  - a_rsel stays at idx.
  - On out_valid&&out_ready:
    - If idx==ORDER: frame_cnt++ (wraps modulo 2^FCNT_W), go to IDLE.
    - Otherwise: idx++, go to RD_ADDR.
- Outside LEV_RUN, a_rsel is driven by the sequencer: idx in the RD_* states, 0 in IDLE and AC_RUN.
- frame_start in any non-IDLE state: ignored and sets overrun. The frame in flight is unaffected.
- frame_start in the same cycle as the return to IDLE: ignored, sets overrun.
- ac_done outside AC_RUN: ignored.
- Sticky flags clear only on reset.
- A timeout abandons the frame: no readout, frame_cnt does not change, lev_reset=1 again from the next cycle.
- out_data and out_last hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset (synchronous, takes effect at the next edge, any state): state=IDLE, lev_reset=1, and all other outputs 0 (busy, ac_start, out_*, a_rsel, flags, frame_cnt). Reset mid-frame aborts with no output.
- frame_start at edge N: ac_start=1 and busy=1 in cycle N+1.
- ac_done seen at edge M: lev_reset=0 from cycle M+1.
- lev_ready seen at edge L: the first out_valid is in cycle L+3.
- Readout takes 3 cycles per word when out_ready=1; full readout is 3·(ORDER+1)=33 cycles at default.
- Watchdog: a counter of width clog2(TIMEOUT) that saturates and resets on every state entry.

## Structure
- Package lpc_pkg holds:
  - the state enum;
  - LPC_ORDER=10;
  - the address widths COEF_AW=10 and R_AW=11;
  - DATA_W=32.
- One sub-module is natural: lpc_watchdog. It is a saturating counter with clear and enable inputs and an expired output; the sequencer instantiates it once.
- The a_rsel mux and the readout index stay in the top module.

## Test plan
- Nominal frame, ORDER=10, memory preloaded with a[i]=i+0x100, out_ready=1:
  - frame_start → ac_start pulse; ac_done 50 cycles later; lev_ready 200 cycles later;
  - expect 11 words 0x100..0x10A, out_last only on 0x10A, frame_cnt=1, busy low afterward.
- Backpressure: out_ready toggles 1,0,0,1 → every word appears exactly once, in order, and is held stable while stalled.
- frame_start pulsed during LEV_RUN → overrun=1, only one frame is streamed, frame_cnt=1.
- ac_done withheld with TIMEOUT=16:
  - expect timeout_err=1 and state IDLE 16 cycles after ac_start, no out_valid, lev_reset=1;
  - a following frame completes normally.
- Reset asserted during RD_OUT at word 5 → next cycle: out_valid=0, lev_reset=1, frame_cnt=0, flags=0.
- a_rsel check:
  - equals lev_a_rsel (random values) throughout LEV_RUN;
  - lev_ready held high from before LEV_RUN: readout starts only after the first LEV_RUN cycle.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC analysis chain.
// Holds the frame-sequencer state encoding and the memory geometry.
package lpc_pkg;

  localparam int LPC_ORDER = 10;
  localparam int COEF_AW   = 10;
  localparam int R_AW      = 11;
  localparam int DATA_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AC_RUN,
    ST_LEV_RUN,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_RD_OUT
  } lpc_state_e;

  // States in which the sequencer owns the coefficient read address.
  function automatic logic is_readout(input lpc_state_e s);
    return (s == ST_RD_ADDR) || (s == ST_RD_WAIT) || (s == ST_RD_OUT);
  endfunction

endpackage

// File: rtl/lpc_watchdog.sv
// Saturating cycle counter with synchronous clear and count enable.
// expired is high while the count sits at LIMIT-1.
module lpc_watchdog #(
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/lpc_frame_sequencer.sv
// Frame scheduler: autocorrelation -> Levinson-Durbin -> coefficient readout.
// Owns the coefficient-memory read address and gates the Levinson reset.
module lpc_frame_sequencer
  import lpc_pkg::*;
#(
  parameter int ORDER   = LPC_ORDER,
  parameter int TIMEOUT = 65535,
  parameter int FCNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  output logic               busy,
  output logic               ac_start,
  input  logic               ac_done,
  output logic               lev_reset,
  input  logic               lev_ready,
  input  logic [COEF_AW-1:0] lev_a_rsel,
  output logic [COEF_AW-1:0] a_rsel,
  input  logic [DATA_W-1:0]  a_r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last,
  output logic               overrun,
  output logic               timeout_err,
  output logic [FCNT_W-1:0]  frame_cnt
);

  localparam logic [COEF_AW-1:0] LAST_IDX = COEF_AW'(ORDER);

  lpc_state_e          state_q, state_d;
  logic [COEF_AW-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;
  logic                ac_start_q, ac_start_d;
  logic                lev_seen_q, lev_seen_d;
  logic                wd_clr, wd_en, wd_expired;

  lpc_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Watchdog restarts on every state entry and only counts in the two run states.
  assign wd_clr = (state_q == ST_IDLE) || (state_d != state_q);
  assign wd_en  = (state_q == ST_AC_RUN) || (state_q == ST_LEV_RUN);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q || (frame_start && (state_q != ST_IDLE));
    timeout_d   = timeout_q;
    ac_start_d  = 1'b0;
    lev_seen_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d    = ST_AC_RUN;
          ac_start_d = 1'b1;
        end
      end
      ST_AC_RUN: begin
        if (ac_done) begin
          state_d = ST_LEV_RUN;
        end else if (wd_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_LEV_RUN: begin
        // lev_ready may be stale from the previous datapath run on entry.
        lev_seen_d = 1'b1;
        if (lev_seen_q && lev_ready) begin
          state_d = ST_RD_ADDR;
          idx_d   = '0;
        end else if (wd_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        out_data_d = a_r;
        state_d    = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            state_d     = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_RD_ADDR;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      ac_start_q  <= 1'b0;
      lev_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      ac_start_q  <= ac_start_d;
      lev_seen_q  <= lev_seen_d;
    end
  end

  always_comb begin
    a_rsel = '0;
    if (state_q == ST_LEV_RUN) begin
      a_rsel = lev_a_rsel;
    end else if (is_readout(state_q)) begin
      a_rsel = idx_q;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign ac_start    = ac_start_q;
  assign lev_reset   = (state_q != ST_LEV_RUN);
  assign out_valid   = (state_q == ST_RD_OUT);
  assign out_data    = out_data_q;
  assign out_last    = (state_q == ST_RD_OUT) && (idx_q == LAST_IDX);
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
